// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and defaults for the serial transmit arbiter
package serial_pkg;
  typedef enum logic [2:0] {ARB_IDLE, ARB_GRANT, ARB_START, ARB_WAIT, ARB_RELEASE, ARB_ABORT} arb_state_e;
  localparam int TX_TIMEOUT_DEF = 255;
endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_arbiter_pick: combinational round-robin pick, first set req bit scanning upward from i_ptr with wrap
module rr_arbiter_pick #(
  parameter int NUM_REQ = 2,
  localparam int SW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SW-1:0]      i_ptr,
  output logic               o_any,
  output logic [SW-1:0]      o_win
);
  always_comb begin
    int j;
    j = 0;
    o_any = 1'b0;
    o_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (i_req[j]) begin
        o_any = 1'b1;
        o_win = SW'(j);
      end
    end
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin owner of one serial transmitter with start, finish wait and watchdog abort
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = TX_TIMEOUT_DEF,
  parameter int TMR_W = 8,
  localparam int SW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               tx_finish,
  output logic               tx_start,
  output logic               tx_abort,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SW-1:0]      sel,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               busy
);
  arb_state_e         r_state;
  logic [SW-1:0]      r_ptr;
  logic [SW-1:0]      r_sel;
  logic [TMR_W-1:0]   r_timer;
  logic               w_any;
  logic [SW-1:0]      w_win;
  logic [NUM_REQ-1:0] w_oh;
  rr_arbiter_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req(req),
    .i_ptr(r_ptr),
    .o_any(w_any),
    .o_win(w_win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: if (w_any) begin
          r_sel   <= w_win;
          r_state <= ARB_GRANT;
        end
        ARB_GRANT: r_state <= ARB_START;
        ARB_START: begin
          r_timer <= '0;
          r_state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (tx_finish) r_state <= ARB_RELEASE;
          else if (r_timer == TMR_W'(TIMEOUT)) r_state <= ARB_ABORT;
          else r_timer <= r_timer + 1'b1;
        end
        ARB_RELEASE, ARB_ABORT: begin
          r_ptr   <= (r_sel == SW'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
  assign w_oh     = NUM_REQ'(1) << r_sel;
  assign gnt      = (r_state inside {ARB_GRANT, ARB_START, ARB_WAIT}) ? w_oh : '0;
  assign tx_start = r_state == ARB_START;
  assign tx_abort = r_state == ARB_ABORT;
  assign done     = (r_state == ARB_RELEASE) ? w_oh : '0;
  assign err      = tx_abort ? w_oh : '0;
  assign busy     = r_state != ARB_IDLE;
  assign sel      = r_sel;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scoreboard bench for serial_tx_arbiter with NUM_REQ=2, TIMEOUT=15
module tb_serial_tx_arbiter;
  localparam int TO = 15;
  typedef struct packed {logic [1:0] done; logic [1:0] err; logic abort;} ev_t;
  logic       clk = 0;
  logic       rst = 1;
  logic [1:0] req = '0;
  logic       tx_finish = 0;
  logic       tx_start, tx_abort, busy;
  logic [1:0] gnt, done, err;
  logic [0:0] sel;
  int         n_cmp = 0;
  int         n_bad = 0;
  ev_t        sb_q[$];
  serial_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(TO), .TMR_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_finish(tx_finish),
    .tx_start(tx_start), .tx_abort(tx_abort), .gnt(gnt), .sel(sel),
    .done(done), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && (done != 0 || err != 0)) begin
      if (sb_q.size() == 0) chk("sb_unexpected", 32'({done, err, tx_abort}), 32'd0);
      else chk("sb_event", 32'({done, err, tx_abort}), 32'(sb_q.pop_front()));
    end
    if (!rst && tx_start) chk("sel_vs_gnt", 32'(gnt), 32'(2'b01 << sel));
  end
  task automatic do_reset;
    rst = 1;
    req = '0;
    tx_finish = 0;
    tick;
    tick;
    rst = 0;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({tx_start, tx_abort, done, err}), 0);
  endtask
  task automatic frame(input logic [1:0] r, input int fin, input int src, input bit drop);
    logic [1:0] oh;
    ev_t e;
    int n;
    oh = 2'b01 << src;
    e.done = (fin >= 0) ? oh : 2'b00;
    e.err = (fin >= 0) ? 2'b00 : oh;
    e.abort = fin < 0;
    sb_q.push_back(e);
    req = r;
    tick;
    chk("grant_gnt", 32'(gnt), 32'(oh));
    chk("grant_sel", 32'(sel), 32'(src));
    chk("grant_start", 32'(tx_start), 0);
    if (drop) req = '0;
    tick;
    chk("tx_start", 32'(tx_start), 1);
    tick;
    chk("wait_gnt", 32'({tx_start, gnt}), 32'({1'b0, oh}));
    if (fin >= 0) begin
      repeat (fin) tick;
      tx_finish = 1;
      tick;
      tx_finish = 0;
      chk("rel_gnt", 32'(gnt), 0);
    end else begin
      n = 0;
      while (!tx_abort && n < 40) begin
        tick;
        n++;
      end
      chk("abort_latency", 32'(n), 32'(TO + 1));
      chk("abort_gnt", 32'(gnt), 0);
    end
    tick;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_gnt", 32'(gnt), 0);
  endtask
  initial begin
    do_reset;
    frame(2'b01, 9, 0, 0);
    req = '0;
    do_reset;
    frame(2'b11, 5, 0, 0);
    frame(2'b11, 5, 1, 0);
    frame(2'b11, 5, 0, 0);
    frame(2'b11, 5, 1, 0);
    frame(2'b10, -1, 1, 0);
    frame(2'b11, 4, 0, 0);
    frame(2'b01, TO, 0, 0);
    req = 2'b10;
    tick;
    tick;
    tick;
    chk("pre_rst_wait", 32'({busy, gnt}), 32'({1'b1, 2'b10}));
    req = '0;
    rst = 1;
    tick;
    rst = 0;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_sel", 32'(sel), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pulses", 32'({tx_start, tx_abort, done, err}), 0);
    tx_finish = 1;
    tick;
    tx_finish = 0;
    chk("idle_finish_busy", 32'(busy), 0);
    chk("idle_finish_done", 32'(done), 0);
    frame(2'b11, 2, 0, 0);
    frame(2'b01, 3, 0, 1);
    req = '0;
    tick;
    tick;
    chk("idle_end_busy", 32'(busy), 0);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
